// File: rtl/ble_hdr_pkg.sv
// Shared constants for the Bluetooth BR packet-header path (TX serializer, RX HEC check).
// Header layout is {seqn, arqn, flow, pkt_type, lt_addr}; bit 0 goes on air first.
package ble_hdr_pkg;

   localparam int HDR_LEN = 10;
   localparam int HEC_LEN = 8;

   // x^8 + x^7 + x^5 + x^2 + x + 1 without the x^8 term
   localparam logic [7:0] HEC_POLY_MASK = 8'hA7;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_LOAD = 3'd1;
   localparam logic [2:0] ST_HDR  = 3'd2;
   localparam logic [2:0] ST_HEC  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   localparam int LT_ADDR_OFS = 0;
   localparam int TYPE_OFS    = 3;
   localparam int FLOW_OFS    = 7;
   localparam int ARQN_OFS    = 8;
   localparam int SEQN_OFS    = 9;

   function automatic logic [HDR_LEN-1:0] pack_header(
      input logic [2:0] lt_addr,
      input logic [3:0] pkt_type,
      input logic       flow,
      input logic       arqn,
      input logic       seqn
   );
      logic [HDR_LEN-1:0] h;
      h                       = '0;
      h[LT_ADDR_OFS +: 3]     = lt_addr;
      h[TYPE_OFS +: 4]        = pkt_type;
      h[FLOW_OFS]             = flow;
      h[ARQN_OFS]             = arqn;
      h[SEQN_OFS]             = seqn;
      return h;
   endfunction

endpackage

// File: rtl/hec8_lfsr_step.sv
// One step of the Bluetooth HEC-8 LFSR, shared by the TX serializer and RX HEC checker.
module hec8_lfsr_step (
   input  logic [7:0] lfsr,
   input  logic       d,
   output logic [7:0] lfsr_next
);
   import ble_hdr_pkg::*;

   logic fb;

   always_comb begin
      fb        = lfsr[7] ^ d;
      lfsr_next = {lfsr[6:0], 1'b0} ^ (fb ? HEC_POLY_MASK : 8'h00);
   end

endmodule

// File: rtl/tx_header_serializer_bluetooth.sv
// Bluetooth BR header transmit stage: 10 header bits LSB-first, then 8 HEC bits MSB-first,
// with a valid/ready bit handshake toward the modulator / FEC 1/3 encoder.
module tx_header_serializer_bluetooth #(
   parameter int HDR_LEN = ble_hdr_pkg::HDR_LEN,
   parameter int HEC_LEN = ble_hdr_pkg::HEC_LEN,
   parameter int CNT_W   = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       abort,
   input  logic [2:0] lt_addr,
   input  logic [3:0] pkt_type,
   input  logic       flow,
   input  logic       arqn,
   input  logic       seqn,
   input  logic [7:0] uap_dci,
   input  logic       bit_ready,
   output logic       bit_out,
   output logic       bit_valid,
   output logic       hec_phase,
   output logic       busy,
   output logic       done
);
   import ble_hdr_pkg::*;

   if ((1 << CNT_W) <= (HDR_LEN + HEC_LEN)) begin : g_bad_cnt_w
      $error("CNT_W too small for HDR_LEN + HEC_LEN");
   end

   logic [2:0]         state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [HDR_LEN-1:0] hdr_reg, hdr_next;
   logic [HEC_LEN-1:0] lfsr_reg, lfsr_next;
   logic [HEC_LEN-1:0] hecsr_reg, hecsr_next;
   logic [HEC_LEN-1:0] lfsr_stepped;
   logic [HEC_LEN-1:0] preset_rev;
   logic               xfer;
   logic               hdr_last;
   logic               hec_last;

   // The LFSR is preset bit-reversed: lfsr[i] = uap_dci[7-i]
   for (genvar gi = 0; gi < HEC_LEN; gi++) begin : g_preset_rev
      assign preset_rev[gi] = uap_dci[HEC_LEN-1-gi];
   end

   hec8_lfsr_step u_hec_step (
      .lfsr      (lfsr_reg),
      .d         (bit_out),
      .lfsr_next (lfsr_stepped)
   );

   always_comb begin
      bit_valid = 1'b0;
      bit_out   = 1'b0;
      hec_phase = 1'b0;
      busy      = (state_reg != ST_IDLE);
      done      = (state_reg == ST_DONE);
      case (state_reg)
         ST_HDR: begin
            bit_valid = 1'b1;
            // hdr_reg shifts right on every transfer, so bit 0 is always hdr[counter]
            bit_out   = hdr_reg[0];
         end
         ST_HEC: begin
            bit_valid = 1'b1;
            bit_out   = hecsr_reg[HEC_LEN-1];
            hec_phase = 1'b1;
         end
         default: ;
      endcase
   end

   assign xfer     = bit_valid && bit_ready;
   assign hdr_last = (cnt_reg == CNT_W'(HDR_LEN - 1));
   assign hec_last = (cnt_reg == CNT_W'(HEC_LEN - 1));

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      hdr_next   = hdr_reg;
      lfsr_next  = lfsr_reg;
      hecsr_next = hecsr_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               hdr_next   = pack_header(lt_addr, pkt_type, flow, arqn, seqn);
               lfsr_next  = preset_rev;
               cnt_next   = '0;
               state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            cnt_next   = '0;
            state_next = ST_HDR;
         end
         ST_HDR: begin
            if (xfer) begin
               lfsr_next = lfsr_stepped;
               hdr_next  = hdr_reg >> 1;
               if (hdr_last) begin
                  // the 10th step's result is the HEC; go straight on without a bubble
                  hecsr_next = lfsr_stepped;
                  cnt_next   = '0;
                  state_next = ST_HEC;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end
         ST_HEC: begin
            if (xfer) begin
               hecsr_next = {hecsr_reg[HEC_LEN-2:0], 1'b0};
               if (hec_last) begin
                  cnt_next   = '0;
                  state_next = ST_DONE;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
            cnt_next   = '0;
         end
      endcase
      if (abort) begin
         state_next = ST_IDLE;
         cnt_next   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         hdr_reg   <= '0;
         lfsr_reg  <= '0;
         hecsr_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         hdr_reg   <= hdr_next;
         lfsr_reg  <= lfsr_next;
         hecsr_reg <= hecsr_next;
      end
   end

endmodule

// File: tb/tb_tx_header_serializer_bluetooth.sv
// Self-checking bench for tx_header_serializer_bluetooth: vector table plus abort/reset sequences,
// with a bit-level scoreboard fed at start and drained by a transfer monitor.
module tb_tx_header_serializer_bluetooth;

   logic       clk = 1'b0;
   logic       reset, start, abort;
   logic [2:0] lt_addr;
   logic [3:0] pkt_type;
   logic       flow, arqn, seqn;
   logic [7:0] uap_dci;
   logic       bit_ready;
   logic       bit_out, bit_valid, hec_phase, busy, done;

   tx_header_serializer_bluetooth dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .lt_addr   (lt_addr),
      .pkt_type  (pkt_type),
      .flow      (flow),
      .arqn      (arqn),
      .seqn      (seqn),
      .uap_dci   (uap_dci),
      .bit_ready (bit_ready),
      .bit_out   (bit_out),
      .bit_valid (bit_valid),
      .hec_phase (hec_phase),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic b;
      logic h;
   } exp_bit_t;

   exp_bit_t exp_q[$];
   exp_bit_t mon_e;
   int       xfer_cnt;
   logic [7:0] hec_got;
   logic     prev_stall;
   logic     prev_bit;

   typedef struct {
      logic [2:0] lt;
      logic [3:0] ty;
      logic       fl, ar, sq;
      logic [7:0] uap;
      logic       hec_known;
      logic [7:0] exp_hec;
      int         ready_mode;     // 0: always 1, 1: high on odd cycles, 2: random
      int         exp_done;       // cycle of done relative to the start cycle, -1 = not fixed
      int         glitch_cyc;     // cycle in which a stray start is pulsed, -1 = none
      logic       start_in_done;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] model_hec(input logic [9:0] h, input logic [7:0] uap);
      logic [7:0] l, n;
      logic       fb;
      for (int i = 0; i < 8; i++) l[i] = uap[7-i];
      for (int k = 0; k < 10; k++) begin
         fb   = l[7] ^ h[k];
         n[0] = fb;
         n[1] = l[0] ^ fb;
         n[2] = l[1] ^ fb;
         n[3] = l[2];
         n[4] = l[3];
         n[5] = l[4] ^ fb;
         n[6] = l[5];
         n[7] = l[6] ^ fb;
         l    = n;
      end
      return l;
   endfunction

   task automatic push_frame(input logic [9:0] h, input logic [7:0] hec);
      exp_bit_t e;
      for (int k = 0; k < 10; k++) begin
         e.b = h[k]; e.h = 1'b0; exp_q.push_back(e);
      end
      for (int k = 7; k >= 0; k--) begin
         e.b = hec[k]; e.h = 1'b1; exp_q.push_back(e);
      end
   endtask

   // Transfer monitor: a transfer is valid&&ready seen mid-cycle, completing on the next rising edge
   initial begin
      prev_stall = 1'b0;
      prev_bit   = 1'b0;
      xfer_cnt   = 0;
      hec_got    = '0;
      forever begin
         @(negedge clk);
         if (!reset && !abort) begin
            if (prev_stall && bit_valid) check("stall_hold", bit_out, prev_bit);
            if (bit_valid && bit_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_xfer", 1, 0);
               end else begin
                  mon_e = exp_q.pop_front();
                  check("bit_out", bit_out, mon_e.b);
                  check("hec_phase", hec_phase, mon_e.h);
               end
               xfer_cnt++;
               if (hec_phase) hec_got = {hec_got[6:0], bit_out};
            end
         end
         prev_stall = bit_valid && !bit_ready && !reset && !abort;
         prev_bit   = bit_out;
      end
   end

   task automatic run_frame(input vec_t v);
      logic [9:0] h;
      logic [7:0] hec_m;
      logic [7:0] hec_req;
      int         done_cyc;
      @(posedge clk); #1;
      check("idle_before_start", busy, 0);
      h       = {v.sq, v.ar, v.fl, v.ty, v.lt};
      hec_m   = model_hec(h, v.uap);
      hec_req = v.hec_known ? v.exp_hec : hec_m;
      lt_addr = v.lt; pkt_type = v.ty; flow = v.fl; arqn = v.ar; seqn = v.sq; uap_dci = v.uap;
      bit_ready = 1'b1;
      exp_q.delete();
      push_frame(h, hec_m);
      xfer_cnt = 0;
      hec_got  = '0;
      start    = 1'b1;
      done_cyc = -1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 1; cyc < 200; cyc++) begin
         case (v.ready_mode)
            0:       bit_ready = 1'b1;
            1:       bit_ready = (cyc % 2 == 1);
            default: bit_ready = 1'($urandom_range(0, 1));
         endcase
         start = (cyc == v.glitch_cyc) || (v.start_in_done && cyc == v.exp_done);
         if (cyc == v.glitch_cyc) begin
            lt_addr = ~v.lt; pkt_type = ~v.ty; seqn = ~v.sq; uap_dci = ~v.uap;
         end
         if (cyc == 1) begin
            check("load_valid", bit_valid, 0);
            check("load_busy", busy, 1);
         end
         if (cyc == 2) check("first_valid", bit_valid, 1);
         @(negedge clk);
         if (done) begin
            done_cyc = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      start     = 1'b0;
      bit_ready = 1'b1;
      check("done_seen", done_cyc != -1, 1);
      if (v.exp_done > 0) check("done_latency", done_cyc, v.exp_done);
      check("done_one_cycle", done, 0);
      check("idle_after_done", busy, 0);
      check("queue_drained", exp_q.size(), 0);
      check("xfer_count", xfer_cnt, 18);
      check("hec_value", hec_got, hec_req);
      $display("frame hdr=%03h uap=%02h mode=%0d done_cyc=%0d hec=%02h", h, v.uap, v.ready_mode, done_cyc, hec_got);
      exp_q.delete();
   endtask

   vec_t vecs[7];
   vec_t zero_v;
   vec_t lt1_v;

   initial begin
      logic seen_done;

      //              lt      ty       fl    ar    sq    uap    known hec    mode done glitch sid
      vecs[0] = '{3'b000, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h00,  0,  20,  -1, 1'b1};
      vecs[1] = '{3'b001, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h16,  0,  20,  -1, 1'b0};
      vecs[2] = '{3'b001, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h16,  1,  38,  -1, 1'b0};
      vecs[3] = '{3'b000, 4'b0000, 1'b0, 1'b0, 1'b0, 8'hFF, 1'b1, 8'hAA,  0,  20,  -1, 1'b0};
      vecs[4] = '{3'b000, 4'b0000, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 8'h16,  0,  20,  -1, 1'b0};
      vecs[5] = '{3'b110, 4'b1001, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b0, 8'h00,  0,  20,   5, 1'b0};
      vecs[6] = '{3'b101, 4'b1010, 1'b1, 1'b0, 1'b1, 8'h47, 1'b0, 8'h00,  2,  -1,  -1, 1'b0};
      zero_v  = vecs[0];
      zero_v.start_in_done = 1'b0;
      lt1_v   = vecs[1];

      reset = 1'b1; start = 1'b0; abort = 1'b0;
      lt_addr = '0; pkt_type = '0; flow = 1'b0; arqn = 1'b0; seqn = 1'b0; uap_dci = '0;
      bit_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_bit_out", bit_out, 0);
      check("rst_bit_valid", bit_valid, 0);
      check("rst_hec_phase", hec_phase, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      reset = 1'b0;

      for (int i = 0; i < 7; i++) run_frame(vecs[i]);

      // abort after the 5th header transfer
      @(posedge clk); #1;
      lt_addr = 3'b011; pkt_type = 4'b0101; flow = 1'b1; arqn = 1'b1; seqn = 1'b0; uap_dci = 8'h3C;
      bit_ready = 1'b1;
      exp_q.delete();
      push_frame({1'b0, 1'b1, 1'b1, 4'b0101, 3'b011}, model_hec({1'b0, 1'b1, 1'b1, 4'b0101, 3'b011}, 8'h3C));
      xfer_cnt = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
      end
      check("abort_xfers_before", xfer_cnt, 5);
      check("abort_valid_before", bit_valid, 1);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      exp_q.delete();
      check("abort_bit_valid", bit_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_hec_phase", hec_phase, 0);
      seen_done = 1'b0;
      repeat (25) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      check("abort_no_done", seen_done, 0);
      $display("abort after 5 transfers: valid=%0b busy=%0b done_seen=%0b", bit_valid, busy, seen_done);
      run_frame(zero_v);

      // reset during the HEC phase
      @(posedge clk); #1;
      lt_addr = 3'b101; pkt_type = 4'b0011; flow = 1'b0; arqn = 1'b1; seqn = 1'b1; uap_dci = 8'hC3;
      bit_ready = 1'b1;
      exp_q.delete();
      push_frame({1'b1, 1'b1, 1'b0, 4'b0011, 3'b101}, model_hec({1'b1, 1'b1, 1'b0, 4'b0011, 3'b101}, 8'hC3));
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (13) begin
         @(posedge clk); #1;
      end
      check("pre_reset_hec_phase", hec_phase, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.delete();
      check("midrst_busy", busy, 0);
      check("midrst_bit_valid", bit_valid, 0);
      check("midrst_hec_phase", hec_phase, 0);
      check("midrst_done", done, 0);
      check("midrst_bit_out", bit_out, 0);
      $display("reset in HEC phase: busy=%0b valid=%0b hec_phase=%0b", busy, bit_valid, hec_phase);
      run_frame(lt1_v);

      // start and abort together in IDLE: abort wins
      @(posedge clk); #1;
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      check("start_abort_busy", busy, 0);
      check("start_abort_valid", bit_valid, 0);
      @(posedge clk); #1;
      check("start_abort_busy2", busy, 0);
      $display("start+abort in IDLE: busy=%0b", busy);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout actual=running required=finished");
      $fatal(1, "watchdog");
   end

endmodule
